spike_raster_fifo: RTL and testbench

//  Downstream of the LIF neuron array: captures the 1-cycle spike outputs of NUM_NEURONS neurons.

---
 rtl/snn_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 75 +++++++
 rtl/spike_raster_fifo.sv | 101 ++++++++++
 tb/tb_spike_raster_fifo.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared SNN raster definitions.
// Default neuron count and timestamp width, the raster entry width and the
// field offsets of one entry {timestamp, spike vector}. The readout serializer
// imports this package too, so both ends agree on the entry layout.
package snn_pkg;

  localparam int SNN_NUM_NEURONS = 4;
  localparam int SNN_TS_WIDTH    = 8;

  // Spike vector occupies the low bits; the timestamp sits directly above it.
  localparam int SNN_SPK_LSB     = 0;

  function automatic int raster_width(input int nn, input int tw);
    return nn + tw;
  endfunction

  function automatic int ts_lsb(input int nn);
    return SNN_SPK_LSB + nn;
  endfunction

  localparam int SNN_RASTER_W = raster_width(SNN_NUM_NEURONS, SNN_TS_WIDTH);
  localparam int SNN_TS_LSB   = ts_lsb(SNN_NUM_NEURONS);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a full-pop bypass.
// A push is accepted while not full, or when full if a pop happens in the
// same cycle (the freed slot is reused at once). The head is read
// combinationally from storage and forced to zero while empty.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   i_flush       empty the FIFO (pointers and level to zero)
//   i_push        push request, i_din is the entry
//   i_pop_req     consumer ready; a pop only happens when non-empty
//   o_dout        head entry (zero while empty)
//   o_valid       FIFO non-empty
//   o_level       number of stored entries, 0..DEPTH
//   o_push_ok     the push request is accepted this cycle
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop_req,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_push_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  logic w_pop;
  logic w_push;
  logic w_full;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_pop   = i_pop_req & (r_level != '0);
  // When full, the head leaves this cycle, so its slot can take the new entry.
  assign w_push  = i_push & (~w_full | w_pop);

  assign o_valid   = (r_level != '0);
  assign o_level   = r_level;
  assign o_push_ok = w_push;
  assign o_dout    = o_valid ? r_mem[r_rd_ptr] : '0;

  // DEPTH is a power of two, so pointers wrap naturally at AW bits.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage carries no reset; unread slots are never visible because the
  // head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push && !reset && !i_flush) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/spike_raster_fifo.sv
// Spike raster capture FIFO.
// Samples the spike outputs of the neuron array every cycle. Each enabled
// cycle with at least one recorded spike becomes one raster entry
// {timestamp, masked spike vector}, buffered for a valid/ready consumer.
// Entries that find the FIFO full are dropped and counted.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   enable             advance timestamp and allow captures
//   flush              empty the FIFO and clear the overflow flag
//   spike_in/mask      neuron spike pulses and per-neuron record mask
//   out_valid/ready    consumer handshake, out_ts/out_spikes = head entry
//   ts_now, ts_wrap    free-running timestamp and its wrap pulse
//   level              stored entries
//   overflow           sticky drop flag (cleared by reset or flush)
//   drop_count         saturating drop counter (cleared by reset only)
module spike_raster_fifo
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = SNN_NUM_NEURONS,
  parameter int TS_WIDTH    = SNN_TS_WIDTH,
  parameter int DEPTH       = 8,
  parameter int DROP_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    flush,
  input  logic [NUM_NEURONS-1:0]  spike_in,
  input  logic [NUM_NEURONS-1:0]  spike_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TS_WIDTH-1:0]     out_ts,
  output logic [NUM_NEURONS-1:0]  out_spikes,
  output logic [TS_WIDTH-1:0]     ts_now,
  output logic                    ts_wrap,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [DROP_WIDTH-1:0]   drop_count
);

  localparam int RW     = raster_width(NUM_NEURONS, TS_WIDTH);
  localparam int TS_LSB = ts_lsb(NUM_NEURONS);

  logic [TS_WIDTH-1:0]    r_ts;
  logic                   r_ts_wrap;
  logic                   r_overflow;
  logic [DROP_WIDTH-1:0]  r_drop_count;

  logic [NUM_NEURONS-1:0] w_vec;
  logic                   w_push_req;
  logic                   w_push_ok;
  logic                   w_drop;
  logic [RW-1:0]          w_din;
  logic [RW-1:0]          w_dout;

  assign w_vec      = spike_in & spike_mask;
  assign w_push_req = enable & (|w_vec);
  // Entry carries the timestamp of the spike cycle itself (pre-increment).
  assign w_din      = {r_ts, w_vec};
  // A flush discards the push outright; that is not a drop.
  assign w_drop     = w_push_req & ~w_push_ok & ~flush;

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_flush   (flush),
    .i_push    (w_push_req),
    .i_pop_req (out_ready),
    .i_din     (w_din),
    .o_dout    (w_dout),
    .o_valid   (out_valid),
    .o_level   (level),
    .o_push_ok (w_push_ok)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts         <= '0;
      r_ts_wrap    <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (enable) r_ts <= r_ts + TS_WIDTH'(1);
      r_ts_wrap <= enable & (&r_ts);
      if (flush)       r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;
      if (w_drop && (r_drop_count != '1)) r_drop_count <= r_drop_count + DROP_WIDTH'(1);
    end
  end

  assign out_ts     = w_dout[TS_LSB +: TS_WIDTH];
  assign out_spikes = w_dout[SNN_SPK_LSB +: NUM_NEURONS];
  assign ts_now     = r_ts;
  assign ts_wrap    = r_ts_wrap;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_spike_raster_fifo.sv
module tb_spike_raster_fifo;

  localparam int NN    = 4;
  localparam int TW    = 8;
  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int TSMAX = (1 << TW) - 1;
  localparam int DMAX  = (1 << DW) - 1;

  logic            clk = 1'b0;
  logic            reset, enable, flush, out_ready;
  logic [NN-1:0]   spike_in, spike_mask;
  logic            out_valid, ts_wrap, overflow;
  logic [TW-1:0]   out_ts, ts_now;
  logic [NN-1:0]   out_spikes;
  logic [$clog2(DEPTH):0] level;
  logic [DW-1:0]   drop_count;

  int checks = 0;
  int errors = 0;

  spike_raster_fifo #(.NUM_NEURONS(NN), .TS_WIDTH(TW), .DEPTH(DEPTH), .DROP_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush),
    .spike_in(spike_in), .spike_mask(spike_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts), .out_spikes(out_spikes),
    .ts_now(ts_now), .ts_wrap(ts_wrap), .level(level), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of {ts, spikes} records plus scalar counters.
  typedef struct { int ts; int spk; } ent_t;
  ent_t m_q[$];
  int   m_ts = 0;
  bit   m_wrap = 0;
  bit   m_ovf = 0;
  int   m_drop = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input bit fl,
                            input int spk, input int msk, input bit rdy);
    bit popped;
    int vec;
    ent_t e;
    if (rst) begin
      m_q.delete(); m_ts = 0; m_wrap = 0; m_ovf = 0; m_drop = 0;
    end else begin
      popped = rdy && (m_q.size() > 0);
      vec = spk & msk;
      if (fl) begin
        m_q.delete();
        m_ovf = 0;
      end else begin
        if (popped) void'(m_q.pop_front());
        if (en && vec != 0) begin
          if (m_q.size() < DEPTH) begin
            e.ts = m_ts; e.spk = vec;
            m_q.push_back(e);
          end else begin
            m_ovf = 1;
            if (m_drop < DMAX) m_drop++;
          end
        end
      end
      m_wrap = en && (m_ts == TSMAX);
      if (en) m_ts = (m_ts + 1) % (TSMAX + 1);
    end
  endtask

  task automatic cmp_model(input string tag);
    bit ne;
    ne = m_q.size() > 0;
    chk({tag, ".valid"},    int'(out_valid),  int'(ne));
    chk({tag, ".level"},    int'(level),      m_q.size());
    chk({tag, ".out_ts"},   int'(out_ts),     ne ? m_q[0].ts : 0);
    chk({tag, ".out_spk"},  int'(out_spikes), ne ? m_q[0].spk : 0);
    chk({tag, ".ts_now"},   int'(ts_now),     m_ts);
    chk({tag, ".ts_wrap"},  int'(ts_wrap),    int'(m_wrap));
    chk({tag, ".overflow"}, int'(overflow),   int'(m_ovf));
    chk({tag, ".drop"},     int'(drop_count), m_drop);
  endtask

  task automatic cyc(input bit rst, input bit en, input bit fl,
                     input int spk, input int msk, input bit rdy, input string tag);
    reset = rst; enable = en; flush = fl; out_ready = rdy;
    spike_in = NN'(spk); spike_mask = NN'(msk);
    model_step(rst, en, fl, spk, msk, rdy);
    @(posedge clk);
    #1;
    cmp_model(tag);
  endtask

  typedef struct {
    bit rst, en, fl, rdy;
    int spk, msk;
    bit ev; int el, ets, espk, etsn; bit eovf; int edrop;
  } vec_t;

  function automatic vec_t mk(bit rst, bit en, bit fl, int spk, int msk, bit rdy,
                              bit ev, int el, int ets, int espk, int etsn, bit eovf, int edrop);
    vec_t v;
    v.rst = rst; v.en = en; v.fl = fl; v.spk = spk; v.msk = msk; v.rdy = rdy;
    v.ev = ev; v.el = el; v.ets = ets; v.espk = espk; v.etsn = etsn; v.eovf = eovf; v.edrop = edrop;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    reset = 1'b1; enable = 1'b0; flush = 1'b0; out_ready = 1'b0;
    spike_in = '0; spike_mask = '1;

    for (int i = 0; i < 5; i++) tbl[i] = mk(0,1,0, 0,15,0, 0,0,0,0, i+1, 0,0);
    tbl[5]  = mk(0,1,0, 5,15,0, 1,1,5,5,  6, 0,0);  // capture at ts 5
    tbl[6]  = mk(0,1,0, 4, 1,0, 1,1,5,5,  7, 0,0);  // masked away
    tbl[7]  = mk(0,0,0,15,15,0, 1,1,5,5,  7, 0,0);  // disabled: frozen, no capture
    tbl[8]  = mk(0,1,0, 8,15,1, 1,1,7,8,  8, 0,0);  // pop + push
    tbl[9]  = mk(0,1,0, 0,15,1, 0,0,0,0,  9, 0,0);  // drain to empty
    tbl[10] = mk(0,1,0, 3,15,1, 1,1,9,3, 10, 0,0);  // empty, push+ready: no pop
    tbl[11] = mk(0,1,1,15,15,1, 0,0,0,0, 11, 0,0);  // flush
    tbl[12] = mk(1,1,0,15,15,1, 0,0,0,0,  0, 0,0);  // reset

    // Reset state
    cyc(1,0,0,0,15,0,"rst");
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ts", int'(ts_now), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_drop", int'(drop_count), 0);
    chk("rst_outts", int'(out_ts), 0);

    // Table vectors
    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].rst, tbl[i].en, tbl[i].fl, tbl[i].spk, tbl[i].msk, tbl[i].rdy, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_valid", i), int'(out_valid),  int'(tbl[i].ev));
      chk($sformatf("tbl%0d_level", i), int'(level),      tbl[i].el);
      chk($sformatf("tbl%0d_outts", i), int'(out_ts),     tbl[i].ets);
      chk($sformatf("tbl%0d_spk", i),   int'(out_spikes), tbl[i].espk);
      chk($sformatf("tbl%0d_tsnow", i), int'(ts_now),     tbl[i].etsn);
      chk($sformatf("tbl%0d_ovf", i),   int'(overflow),   int'(tbl[i].eovf));
      chk($sformatf("tbl%0d_drop", i),  int'(drop_count), tbl[i].edrop);
    end

    // Reset mid-run with entries queued at ts 37
    repeat (34) cyc(0,1,0,0,15,0,"t1run");
    for (int i = 0; i < 3; i++) cyc(0,1,0,1<<i,15,0,"t1spk");
    chk("t1_pre_level", int'(level), 3);
    chk("t1_pre_ts", int'(ts_now), 37);
    cyc(1,1,0,15,15,1,"t1rst");
    chk("t1_ts", int'(ts_now), 0);
    chk("t1_level", int'(level), 0);
    chk("t1_valid", int'(out_valid), 0);
    chk("t1_ovf", int'(overflow), 0);
    chk("t1_drop", int'(drop_count), 0);

    // Overflow: 10 spikes into 8 entries
    for (int i = 0; i < 10; i++) cyc(0,1,0,(i+1)&15,15,0,"t3");
    chk("t3_level", int'(level), 8);
    chk("t3_ovf", int'(overflow), 1);
    chk("t3_drop", int'(drop_count), 2);
    chk("t3_head_ts", int'(out_ts), 0);
    chk("t3_head_spk", int'(out_spikes), 1);

    // Full with simultaneous pop
    cyc(0,1,0,10,15,1,"t4");
    chk("t4_level", int'(level), 8);
    chk("t4_drop", int'(drop_count), 2);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_drain%0d_ts", i),  int'(out_ts),     (i < 7) ? i+1 : 10);
      chk($sformatf("t4_drain%0d_spk", i), int'(out_spikes), (i < 7) ? i+2 : 10);
      cyc(0,0,0,0,15,1,"t4drain");
    end
    chk("t4_empty", int'(level), 0);
    chk("t4_ovf_sticky", int'(overflow), 1);

    // Flush with push and pop
    for (int i = 0; i < 5; i++) cyc(0,1,0,3,15,0,"t6fill");
    chk("t6_pre_level", int'(level), 5);
    cyc(0,1,1,15,15,1,"t6flush");
    chk("t6_level", int'(level), 0);
    chk("t6_valid", int'(out_valid), 0);
    chk("t6_ovf", int'(overflow), 0);
    chk("t6_drop", int'(drop_count), 2);

    // Drop counter saturation
    repeat (DEPTH + 260) cyc(0,1,0,1,15,0,"sat");
    chk("sat_drop", int'(drop_count), DMAX);
    cyc(0,1,0,1,15,0,"sat2");
    chk("sat_hold", int'(drop_count), DMAX);
    chk("sat_ovf", int'(overflow), 1);

    // Timestamp wrap
    cyc(1,0,0,0,15,1,"t5rst");
    repeat (254) cyc(0,1,0,0,15,0,"t5run");
    chk("t5_ts254", int'(ts_now), 254);
    cyc(0,1,0,0,15,0,"t5a");
    chk("t5_ts255", int'(ts_now), 255);
    chk("t5_nowrap", int'(ts_wrap), 0);
    cyc(0,1,0,1,15,0,"t5b");
    chk("t5_ts0", int'(ts_now), 0);
    chk("t5_wrap", int'(ts_wrap), 1);
    chk("t5_head_ts", int'(out_ts), 255);
    cyc(0,0,0,15,15,0,"t5c");
    chk("t5_frozen", int'(ts_now), 0);
    chk("t5_wrap_off", int'(ts_wrap), 0);
    chk("t5_nocap", int'(level), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 299) == 0,
          $urandom_range(0, 7) != 0,
          $urandom_range(0, 79) == 0,
          int'($urandom_range(0, 15)),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 15,
          $urandom_range(0, 99) < (((i / 250) % 2 == 0) ? 30 : 75),
          "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
